// File: rtl/result_frame_packer_pkg.sv
// Shared constants, length derivation and state encoding for the
// result frame packer; the controller uses the same formulas.
package result_frame_packer_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_SEQ,
    ST_PAYLOAD,
    ST_PAD,
    ST_CSUM
  } pack_state_e;

  // Correction bits produced per measurement round.
  function automatic int correction_count_per_round(
    input int x,
    input int z
  );
    return 2 * (x - 1) * z + 1 + x * z;
  endfunction

  // Iteration byte, two cycle bytes, then packed corrections per round.
  function automatic logic [15:0] payload_bytes(
    input int x,
    input int z,
    input int u
  );
    int c;
    int n;
    c = correction_count_per_round(x, z);
    n = 3 + ((c + 7) >>> 3) * u;
    return n[15:0];
  endfunction

endpackage

// File: rtl/result_frame_packer_timeout.sv
// Idle-cycle counter: counts while inc is high, saturates at LIMIT.
// Ports: clk, reset, clear, inc; expired is high once LIMIT is reached.
module frame_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables expiry entirely.
  assign expired = (LIMIT > 0) && (cnt_q == LIM);

endmodule

// File: rtl/result_frame_packer.sv
// Wraps each decode result in a host-link frame:
// sync, 16-bit length, seq, payload, XOR checksum.
// Ports: in_* byte stream from controller (valid/ready),
// out_* framed bytes to host (valid/ready), frame_count, abort_pulse.
module result_frame_packer
  import result_frame_packer_pkg::*;
#(
  parameter int         GRID_WIDTH_X   = 4,
  parameter int         GRID_WIDTH_Z   = 1,
  parameter int         GRID_WIDTH_U   = 3,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic        abort_pulse
);

  localparam logic [15:0] PLEN =
    payload_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
  localparam logic [15:0] PLAST = PLEN - 16'd1;

  pack_state_e state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] fc_q, fc_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        abort_q, abort_d;

  logic in_payload;
  logic to_clear;
  logic to_inc;
  logic to_expired;

  assign in_payload = (state_q == ST_PAYLOAD);
  // Any present byte restarts the idle count, even when stalled.
  assign to_clear   = !in_payload || in_valid;
  assign to_inc     = in_payload && !in_valid;

  frame_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .inc    (to_inc),
    .expired(to_expired)
  );

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    fc_d        = fc_q;
    csum_d      = csum_q;
    bcnt_d      = bcnt_q;
    abort_d     = abort_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    abort_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        out_valid = 1'b1;
        out_data  = PLEN[15:8];
        if (out_ready) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        out_valid = 1'b1;
        out_data  = PLEN[7:0];
        if (out_ready) state_d = ST_SEQ;
      end
      ST_SEQ: begin
        out_valid = 1'b1;
        out_data  = seq_q;
        if (out_ready) begin
          state_d = ST_PAYLOAD;
          csum_d  = PLEN[15:8] ^ PLEN[7:0] ^ seq_q;
          bcnt_d  = '0;
          abort_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        out_valid = in_valid;
        out_data  = in_data;
        in_ready  = out_ready;
        if (in_valid && out_ready) begin
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 16'd1;
          if (bcnt_q == PLAST) state_d = ST_CSUM;
        end else if (to_expired && !in_valid) begin
          state_d = ST_PAD;
          abort_d = 1'b1;
        end
      end
      ST_PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          bcnt_d = bcnt_q + 16'd1;
          if (bcnt_q == PLAST) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        // Inverted checksum tells the host to drop an aborted frame.
        out_data  = abort_q ? ~csum_q : csum_q;
        if (out_ready) begin
          seq_d       = seq_q + 8'd1;
          fc_d        = fc_q + 16'd1;
          abort_pulse = abort_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      fc_q    <= '0;
      csum_q  <= '0;
      bcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      fc_q    <= fc_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      abort_q <= abort_d;
    end
  end

  assign frame_count = fc_q;

endmodule

// File: tb/tb_result_frame_packer.sv
// Randomized bench for result_frame_packer against a queue-based
// frame model; abort, reset and sequence wrap included.
module tb_result_frame_packer;

  localparam int TO = 8;
  localparam int CORR = 2 * (4 - 1) * 1 + 1 + 4 * 1;
  localparam int PB = 3 + ((CORR + 7) / 8) * 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] frame_count;
  logic        abort_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int abort_cnt = 0;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] got[$];
  logic [7:0] exp_seq = 8'h00;
  int exp_fc = 0;

  result_frame_packer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_count(frame_count),
    .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Transfers and stall stability observed mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_d));
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (abort_pulse) abort_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
    end
  end

  task automatic drive_bytes(
    input logic [7:0] b[$],
    input int         gmax
  );
    bit x;
    int guard;
    foreach (b[i]) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gmax)) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = b[i];
      guard = 0;
      do begin
        @(negedge clk);
        x = in_valid && in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!x && guard < 2000);
      if (!x) begin
        check("in_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  // Model: header, payload (zero-padded after abort), checksum.
  task automatic expect_frame(
    input logic [7:0] pl[$],
    input int         sent,
    input string      tag
  );
    logic [7:0] exp[$];
    logic [7:0] cs;
    int guard;
    exp.push_back(8'hA5);
    exp.push_back(8'(PB >> 8));
    exp.push_back(8'(PB));
    exp.push_back(exp_seq);
    cs = 8'(PB >> 8) ^ 8'(PB) ^ exp_seq;
    for (int i = 0; i < PB; i++) begin
      if (i < sent) begin
        exp.push_back(pl[i]);
        cs ^= pl[i];
      end else begin
        exp.push_back(8'h00);
      end
    end
    exp.push_back(sent < PB ? ~cs : cs);
    guard = 0;
    while (got.size() < exp.size() && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) check(tag, 32'(got[i]), 32'(exp[i]));
    end
    got.delete();
    exp_seq = exp_seq + 8'd1;
    exp_fc = exp_fc + 1;
    check({tag, "_fc"}, 32'(frame_count), 32'(exp_fc & 16'hFFFF));
  endtask

  task automatic rand_frame(input int gmax, input string tag);
    logic [7:0] pl[$];
    for (int i = 0; i < PB; i++) pl.push_back(8'($urandom));
    drive_bytes(pl, gmax);
    expect_frame(pl, PB, tag);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] part[$];
    int a0;

    #23;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_abort", 32'(abort_pulse), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < PB; i++) pl.push_back(8'h00);
    drive_bytes(pl, 0);
    expect_frame(pl, PB, "zero_frame");

    pl.delete();
    for (int i = 1; i <= PB; i++) pl.push_back(8'(i));
    drive_bytes(pl, 0);
    expect_frame(pl, PB, "count_frame");
    check("no_abort_yet", 32'(abort_cnt), 32'd0);

    rand_ready = 1'b1;
    for (int f = 0; f < 10; f++) rand_frame(TO / 2, "stall_frame");

    pl.delete();
    for (int i = 0; i < PB; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) part.push_back(pl[i]);
    a0 = abort_cnt;
    drive_bytes(part, 2);
    expect_frame(pl, 4, "abort_frame");
    check("abort_pulses", 32'(abort_cnt - a0), 32'd1);

    rand_ready = 1'b0;
    rand_frame(2, "post_abort");

    part.delete();
    for (int i = 0; i < 3; i++) part.push_back(8'($urandom));
    drive_bytes(part, 0);
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got.delete();
    exp_seq = 8'h00;
    exp_fc = 0;
    check("post_rst_fc", 32'(frame_count), 32'd0);

    rand_ready = 1'b1;
    for (int f = 0; f < 256; f++) rand_frame(1, "wrap_frame");
    check("fc_256", 32'(frame_count), 32'd256);
    rand_frame(1, "seq_wrapped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
